// File: rtl/imem_fetch_window_if.sv
// imem_fetch_window_if: request/window handshake and instruction SRAM read port.
interface imem_fetch_window_if #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 10
);
  localparam int BYTES = DATA_W / 8;
  logic                      mem_req_b;
  logic [15:0]               expectedBytes;
  logic [DATA_W-1:0]         imem_rdata;
  logic                      imem_ceb;
  logic                      imem_web;
  logic [ADDR_W-1:0]         imem_addr;
  logic                      mem_ack_b;
  logic [WORDS*DATA_W-1:0]   instruction_word;
  logic [WORDS*BYTES-1:0]    instruction_valid_bytes;
  logic                      done_reading_memory;
  modport master (
    output mem_req_b, expectedBytes, imem_rdata,
    input  imem_ceb, imem_web, imem_addr, mem_ack_b,
           instruction_word, instruction_valid_bytes, done_reading_memory
  );
  modport slave (
    input  mem_req_b, expectedBytes, imem_rdata,
    output imem_ceb, imem_web, imem_addr, mem_ack_b,
           instruction_word, instruction_valid_bytes, done_reading_memory
  );
endinterface

// File: rtl/imem_fetch_window.sv
// imem_fetch_window: streams pipelined SRAM reads into a WORDS-wide instruction window with a byte-valid mask.
module imem_fetch_window #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 10
) (
  input logic                clk,
  input logic                resetB,
  input logic                restart_b,
  imem_fetch_window_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int WB    = WORDS * BYTES;
  localparam int WW    = WORDS * DATA_W;
  localparam int SW    = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int NB    = $clog2(BYTES + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ACK, WAIT_REL, DONE} state_t;
  state_t            state, state_n;
  logic              ceb, ceb_n, ack, ack_n, done, done_n, cap_vld, cap_vld_n, req_q;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [WW-1:0]     win, win_n;
  logic [WB-1:0]     mask, mask_n;
  logic [16:0]       cnt, cnt_n, e17, inc, sat, rem;
  logic [15:0]       e_q, e_n;
  logic [SW-1:0]     left, left_n, cap_slot, cap_slot_n;
  logic [NB-1:0]     cap_nb, cap_nb_n, nb;
  logic [BYTES-1:0]  ones;
  assign ones = '1;
  assign e17  = {1'b0, e_q};
  assign inc  = cnt + 17'(BYTES);
  assign sat  = inc > e17 ? e17 : inc;
  assign rem  = e17 - cnt;
  assign nb   = rem >= 17'(BYTES) ? NB'(BYTES) : rem[NB-1:0];
  // Slots count down so slot WORDS-1 (word 0 of the window) lands in the MSBs.
  always_comb begin
    state_n    = state;
    ceb_n      = 1'b1;
    ack_n      = 1'b1;
    done_n     = done;
    addr_n     = addr;
    cnt_n      = cnt;
    e_n        = e_q;
    left_n     = left;
    win_n      = win;
    mask_n     = mask;
    cap_vld_n  = 1'b0;
    cap_slot_n = cap_slot;
    cap_nb_n   = cap_nb;
    if (cap_vld) begin
      win_n[cap_slot*DATA_W +: DATA_W] = bus.imem_rdata;
      mask_n[cap_slot*BYTES +: BYTES]  = ~(ones >> cap_nb);
    end
    case (state)
      IDLE: if (!bus.mem_req_b) begin
        e_n    = bus.expectedBytes;
        win_n  = '0;
        mask_n = '0;
        if (cnt >= {1'b0, bus.expectedBytes}) begin
          done_n  = 1'b1;
          ack_n   = 1'b0;
          state_n = DONE;
        end else begin
          ceb_n   = 1'b0;
          left_n  = SW'(WORDS - 1);
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cap_vld_n  = 1'b1;
        cap_slot_n = left;
        cap_nb_n   = nb;
        addr_n     = addr + ADDR_W'(1);
        cnt_n      = sat;
        left_n     = left - SW'(1);
        if (left != '0 && sat < e17) ceb_n = 1'b0;
        else state_n = DRAIN;
      end
      DRAIN: begin
        ack_n   = 1'b0;
        done_n  = cnt >= e17;
        state_n = ACK;
      end
      ACK: state_n = WAIT_REL;
      WAIT_REL: if (bus.mem_req_b) state_n = done ? DONE : IDLE;
      // Only a fresh falling edge of the request earns another (empty) ack.
      DONE: if (!bus.mem_req_b && req_q) begin
        ack_n  = 1'b0;
        win_n  = '0;
        mask_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetB || !restart_b) begin
      state    <= IDLE;
      ceb      <= 1'b1;
      ack      <= 1'b1;
      done     <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
      e_q      <= '0;
      left     <= '0;
      win      <= '0;
      mask     <= '0;
      cap_vld  <= 1'b0;
      cap_slot <= '0;
      cap_nb   <= '0;
      req_q    <= 1'b1;
    end else begin
      state    <= state_n;
      ceb      <= ceb_n;
      ack      <= ack_n;
      done     <= done_n;
      addr     <= addr_n;
      cnt      <= cnt_n;
      e_q      <= e_n;
      left     <= left_n;
      win      <= win_n;
      mask     <= mask_n;
      cap_vld  <= cap_vld_n;
      cap_slot <= cap_slot_n;
      cap_nb   <= cap_nb_n;
      req_q    <= bus.mem_req_b;
    end
  end
  assign bus.imem_ceb                = ceb;
  assign bus.imem_web                = 1'b1;
  assign bus.imem_addr               = addr;
  assign bus.mem_ack_b               = ack;
  assign bus.instruction_word        = win;
  assign bus.instruction_valid_bytes = mask;
  assign bus.done_reading_memory     = done;
endmodule

// File: tb/tb_imem_fetch_window.sv
// tb_imem_fetch_window: directed stimulus with address/window scoreboards checked by a negedge monitor.
module tb_imem_fetch_window;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 10;
  localparam int WB     = WORDS * DATA_W / 8;
  localparam int WW     = WORDS * DATA_W;
  typedef struct {
    logic [WW-1:0] w;
    logic [WB-1:0] m;
  } win_t;
  logic clk = 1'b0;
  logic resetB = 1'b0;
  logic restart_b = 1'b1;
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] addr_q [$];
  win_t win_q [$];
  win_t e;
  int total = 0, bad = 0, ack_cnt = 0, ceb_cnt = 0, c0 = 0;
  imem_fetch_window_if #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W)) bus ();
  imem_fetch_window #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetB(resetB), .restart_b(restart_b), .bus(bus)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = 32'hA0 + 32'(i);
  always @(posedge clk) if (!bus.imem_ceb) bus.imem_rdata <= sram[bus.imem_addr];
  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [WW-1:0] masked(input logic [WW-1:0] w, input logic [WB-1:0] m);
    for (int b = 0; b < WB; b++) if (!m[b]) w[b*8 +: 8] = '0;
    return w;
  endfunction
  function automatic win_t mkwin(input int start, input int n, input logic [WB-1:0] m);
    win_t r;
    r.w = '0;
    r.m = m;
    for (int i = 0; i < n; i++) r.w[(WORDS-1-i)*DATA_W +: DATA_W] = 32'hA0 + 32'(start + i);
    return r;
  endfunction
  always @(negedge clk) begin
    if (bus.imem_ceb === 1'b0) begin
      ceb_cnt++;
      if (addr_q.size() == 0) chk("ceb_extra", addr_q.size(), 1);
      else chk("ceb_addr", bus.imem_addr, addr_q.pop_front());
    end
    if (bus.mem_ack_b === 1'b0) begin
      ack_cnt++;
      if (win_q.size() == 0) chk("ack_extra", win_q.size(), 1);
      else begin
        e = win_q.pop_front();
        chk("win_mask", bus.instruction_valid_bytes, e.m);
        chk("win_word", masked(bus.instruction_word, e.m), masked(e.w, e.m));
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic req(input logic [15:0] eb);
    bus.expectedBytes = eb;
    bus.mem_req_b = 1'b0;
  endtask
  task automatic push_fill(input int start, input int n, input logic [WB-1:0] m, input bit with_win);
    for (int i = 0; i < n; i++) addr_q.push_back(ADDR_W'(start + i));
    if (with_win) win_q.push_back(mkwin(start, n, m));
  endtask
  task automatic wait_ack(input int target);
    int k = 0;
    while (ack_cnt < target && k < 40) begin
      @(posedge clk);
      k++;
    end
    chk("ack_timeout", ack_cnt >= target, 1);
  endtask
  task automatic restart_pulse();
    restart_b = 1'b0;
    @(negedge clk);
    restart_b = 1'b1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ceb_ack_done_addr"}, {bus.imem_ceb, bus.mem_ack_b, bus.done_reading_memory, bus.imem_addr},
        {1'b1, 1'b1, 1'b0, 10'd0});
    chk({tag, "_mask"}, bus.instruction_valid_bytes, 0);
    chk({tag, "_word"}, bus.instruction_word, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    bus.mem_req_b = 1'b1;
    bus.expectedBytes = '0;
    cyc(3);
    chk_reset_vals("reset");
    chk("reset_web", bus.imem_web, 1);
    resetB = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {bus.imem_ceb, bus.mem_ack_b, bus.done_reading_memory, bus.imem_addr}, {1'b1, 1'b1, 1'b0, 10'd0});
    end
    push_fill(0, 4, 16'hFFFF, 1);
    req(16);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t2_ceb", bus.imem_ceb, k <= 4 ? 1'b0 : 1'b1);
      chk("t2_ack", bus.mem_ack_b, k == 6 ? 1'b0 : 1'b1);
    end
    chk("t2_done", bus.done_reading_memory, 1);
    cyc(3);
    chk("t2_no_retrigger", ack_cnt, 1);
    bus.mem_req_b = 1'b1;
    cyc(3);
    chk("t2_done_hold", bus.done_reading_memory, 1);
    chk("t2_ceb_pulses", ceb_cnt, 4);
    restart_b = 1'b0;
    @(negedge clk);
    chk("rs_done", bus.done_reading_memory, 0);
    chk("rs_mask", bus.instruction_valid_bytes, 0);
    restart_b = 1'b1;
    push_fill(0, 4, 16'hFFFF, 1);
    req(22);
    wait_ack(2);
    @(negedge clk);
    chk("t3_done1", bus.done_reading_memory, 0);
    bus.mem_req_b = 1'b1;
    cyc(2);
    c0 = ceb_cnt;
    push_fill(4, 2, 16'hFC00, 1);
    req(22);
    wait_ack(3);
    @(negedge clk);
    chk("t3_pulses", ceb_cnt - c0, 2);
    chk("t3_done2", bus.done_reading_memory, 1);
    bus.mem_req_b = 1'b1;
    cyc(2);
    win_q.push_back(mkwin(0, 0, '0));
    req(22);
    wait_ack(4);
    @(negedge clk);
    chk("done_no_ceb", ceb_cnt - c0, 2);
    bus.mem_req_b = 1'b1;
    cyc(2);
    restart_pulse();
    c0 = ceb_cnt;
    win_q.push_back(mkwin(0, 0, '0));
    req(0);
    wait_ack(5);
    @(negedge clk);
    chk("t4_done", bus.done_reading_memory, 1);
    chk("t4_no_ceb", ceb_cnt - c0, 0);
    bus.mem_req_b = 1'b1;
    cyc(2);
    restart_pulse();
    push_fill(0, 3, '0, 0);
    req(16);
    cyc(3);
    chk("t5_at_addr2", {bus.imem_ceb, bus.imem_addr}, {1'b0, 10'd2});
    restart_b = 1'b0;
    bus.mem_req_b = 1'b1;
    @(negedge clk);
    chk("t5_after", {bus.imem_ceb, bus.mem_ack_b, bus.imem_addr}, {1'b1, 1'b1, 10'd0});
    chk("t5_mask", bus.instruction_valid_bytes, 0);
    restart_b = 1'b1;
    chk("t5_addr_q", addr_q.size(), 0);
    push_fill(0, 4, 16'hFFFF, 1);
    req(16);
    wait_ack(6);
    bus.mem_req_b = 1'b1;
    cyc(2);
    restart_pulse();
    push_fill(0, 4, 16'hFFFF, 1);
    req(16);
    cyc(6);
    chk("t6_in_ack", bus.mem_ack_b, 0);
    resetB = 1'b0;
    push_fill(0, 4, 16'hFFFF, 1);
    @(negedge clk);
    chk_reset_vals("t6_reset");
    resetB = 1'b1;
    wait_ack(8);
    @(negedge clk);
    chk("t6_done", bus.done_reading_memory, 1);
    bus.mem_req_b = 1'b1;
    cyc(2);
    chk("end_addr_q", addr_q.size(), 0);
    chk("end_win_q", win_q.size(), 0);
    chk("end_acks", ack_cnt, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
